// File: rtl/weights_mem_pkg.sv
// Shared constants and types for the arbitrated weights memory.
// Default sizes here match the top-level parameter defaults.
package weights_mem_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8192;
    localparam int ADDR_W = 13;

    typedef logic [DATA_W-1:0] weight_t;
    typedef logic [ADDR_W-1:0] waddr_t;

    // Index width for n sources, never below 1 bit.
    function automatic int src_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past
// the winner so every requester is served within N grants.
module rr_arbiter
    import weights_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = src_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr;
    int            j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!gnt_any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                gnt_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/weights_mem_arb.sv
// NUM_SRC-way round-robin port A plus dedicated loader port B on a TDP RAM.
// Define WEIGHTS_MEM_ARB_FWD_EN for cross-port write-to-read forwarding.
module weights_mem_arb #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8192,
    parameter int ADDR_W  = 13,
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*ADDR_W-1:0] addr,
    input  logic [NUM_SRC-1:0]        wren,
    input  logic [NUM_SRC*DATA_W-1:0] wdata,
    output logic [NUM_SRC-1:0]        gnt,
    output logic                      rd_valid,
    output logic [SRC_W-1:0]          rd_src,
    output logic [DATA_W-1:0]         rd_data,
    input  logic [ADDR_W-1:0]         addr_b,
    input  logic                      wren_b,
    input  logic [DATA_W-1:0]         data_b,
    input  logic                      rd_b,
    output logic                      q_b_valid,
    output logic [DATA_W-1:0]         q_b
);

    import weights_mem_pkg::*;

    logic [SRC_W-1:0]  g_idx;
    logic              g_any;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wd;
    logic              a_acc;
    logic              a_we;
    logic              a_re;
    logic              a_in;
    logic              b_we;
    logic              b_re;
    logic              b_in;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;

    logic              s1_a_v;
    logic [SRC_W-1:0]  s1_a_src;
    logic [DATA_W-1:0] s1_a_q;
    logic              s1_b_v;
    logic [DATA_W-1:0] s1_b_q;

    logic [DATA_W-1:0] mem [DEPTH];

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (SRC_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (g_idx),
        .gnt_any (g_any)
    );

    assign a_addr = addr[int'(g_idx)*ADDR_W +: ADDR_W];
    assign a_wd   = wdata[int'(g_idx)*DATA_W +: DATA_W];

    // A grant seen while reset is high never reaches the RAM.
    assign a_acc = g_any & ~rst;
    assign a_we  = a_acc & wren[g_idx];
    assign a_re  = a_acc & ~wren[g_idx];
    assign a_in  = 32'(a_addr) < DEPTH;

    assign b_we  = wren_b;
    assign b_re  = rd_b & ~wren_b & ~rst;
    assign b_in  = 32'(addr_b) < DEPTH;

    always_comb begin
        a_rd = a_in ? mem[a_addr] : '0;
        b_rd = b_in ? mem[addr_b] : '0;
`ifdef WEIGHTS_MEM_ARB_FWD_EN
        if (b_we && b_in && addr_b == a_addr) a_rd = data_b;
        if (a_we && a_in && a_addr == addr_b) b_rd = a_wd;
`endif
    end

    // Port B write is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (a_we && a_in) mem[a_addr] <= a_wd;
        if (b_we && b_in) mem[addr_b] <= data_b;
    end

    always_ff @(posedge clk) begin
        if (a_re) begin
            s1_a_q   <= a_rd;
            s1_a_src <= g_idx;
        end
        if (b_re) s1_b_q <= b_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_v    <= 1'b0;
            s1_b_v    <= 1'b0;
            rd_valid  <= 1'b0;
            q_b_valid <= 1'b0;
            rd_src    <= '0;
            rd_data   <= '0;
            q_b       <= '0;
        end else begin
            s1_a_v    <= a_re;
            s1_b_v    <= b_re;
            rd_valid  <= s1_a_v;
            q_b_valid <= s1_b_v;
            if (s1_a_v) begin
                rd_src  <= s1_a_src;
                rd_data <= s1_a_q;
            end
            if (s1_b_v) q_b <= s1_b_q;
        end
    end

endmodule

// File: tb/tb_weights_mem_arb.sv
// Directed scoreboard bench for weights_mem_arb (4 sources, DEPTH 8000).
// Expected reads are queued with their due cycle and checked on negedge.
module tb_weights_mem_arb;

    import weights_mem_pkg::*;

    localparam int NS     = 4;
    localparam int AW     = 13;
    localparam int DW     = 16;
    localparam int TDEPTH = 8000;

`ifdef WEIGHTS_MEM_ARB_FWD_EN
    localparam logic [15:0] EXP7  = 16'h0BEE;
    localparam logic [15:0] EXP11 = 16'h0C0C;
`else
    localparam logic [15:0] EXP7  = 16'h0007;
    localparam logic [15:0] EXP11 = 16'h000B;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NS-1:0]    req;
    logic [NS*AW-1:0] addr;
    logic [NS-1:0]    wren;
    logic [NS*DW-1:0] wdata;
    logic [NS-1:0]    gnt;
    logic             rd_valid;
    logic [1:0]       rd_src;
    weight_t          rd_data;
    logic [AW-1:0]    addr_b;
    logic             wren_b;
    weight_t          data_b;
    logic             rd_b;
    logic             q_b_valid;
    weight_t          q_b;

    typedef struct {
        int      src;
        weight_t data;
        int      due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    logic eva;
    logic evb;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   cnt [NS];

    weights_mem_arb #(
        .DATA_W  (DW),
        .DEPTH   (TDEPTH),
        .ADDR_W  (AW),
        .NUM_SRC (NS),
        .SRC_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .wren      (wren),
        .wdata     (wdata),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_src    (rd_src),
        .rd_data   (rd_data),
        .addr_b    (addr_b),
        .wren_b    (wren_b),
        .data_b    (data_b),
        .rd_b      (rd_b),
        .q_b_valid (q_b_valid),
        .q_b       (q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            eva = (qa.size() > 0) && (qa[0].due == cyc);
            chk("rd_valid", 32'(rd_valid), 32'(eva));
            if (eva) begin
                ea = qa.pop_front();
                chk("rd_src", 32'(rd_src), 32'(ea.src));
                chk("rd_data", 32'(rd_data), 32'(ea.data));
            end
            evb = (qb.size() > 0) && (qb[0].due == cyc);
            chk("q_b_valid", 32'(q_b_valid), 32'(evb));
            if (evb) begin
                eb = qb.pop_front();
                chk("q_b", 32'(q_b), 32'(eb.data));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue_a(input int src, input logic we, input int a,
                           input weight_t wd, input weight_t exp_d,
                           input logic [NS-1:0] exp_g);
        req  = '0;
        wren = '0;
        req[src]  = 1'b1;
        wren[src] = we;
        addr[src*AW +: AW]  = AW'(a);
        wdata[src*DW +: DW] = wd;
        #1;
        chk($sformatf("gnt_src%0d", src), 32'(gnt), 32'(exp_g));
        if (!we) qa.push_back('{src, exp_d, cyc + 2});
        tick();
        req  = '0;
        wren = '0;
    endtask

    task automatic set_b(input logic we, input logic rd, input int a,
                         input weight_t d, input weight_t exp_d);
        wren_b = we;
        rd_b   = rd;
        addr_b = AW'(a);
        data_b = d;
        if (rd && !we) qb.push_back('{0, exp_d, cyc + 2});
    endtask

    task automatic clear_b();
        wren_b = 1'b0;
        rd_b   = 1'b0;
    endtask

    task automatic b_op(input logic we, input logic rd, input int a,
                        input weight_t d, input weight_t exp_d);
        set_b(we, rd, a, d, exp_d);
        tick();
        clear_b();
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        req    = '0;
        addr   = '0;
        wren   = '0;
        wdata  = '0;
        addr_b = '0;
        wren_b = 1'b0;
        data_b = '0;
        rd_b   = 1'b0;
        repeat (3) tick();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_q_b_valid", 32'(q_b_valid), 0);
        chk("rst_rd_src", 32'(rd_src), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_q_b", 32'(q_b), 0);
        rst = 1'b0;
        tick();

        b_op(1'b1, 1'b0, 5, 16'h1234, 0);
        for (int i = 0; i < 4; i++) b_op(1'b1, 1'b0, i, 16'(16'hA0 + i), 0);
        b_op(1'b1, 1'b0, 7, 16'h0007, 0);
        b_op(1'b1, 1'b0, 11, 16'h000B, 0);
        b_op(1'b1, 1'b0, 20, 16'h0020, 0);

        issue_a(2, 1'b0, 5, 0, 16'h1234, 4'b0100);
        drain();

        for (int i = 0; i < 4; i++)
            issue_a(0, 1'b0, i, 0, 16'(16'hA0 + i), 4'b0001);
        drain();

        set_b(1'b1, 1'b0, 9, 16'h2222, 0);
        issue_a(1, 1'b1, 9, 16'h1111, 0, 4'b0010);
        clear_b();
        issue_a(3, 1'b0, 9, 0, 16'h2222, 4'b1000);
        b_op(1'b0, 1'b1, 9, 0, 16'h2222);
        drain();

        set_b(1'b1, 1'b0, 7, 16'h0BEE, 0);
        issue_a(0, 1'b0, 7, 0, EXP7, 4'b0001);
        clear_b();
        issue_a(0, 1'b0, 7, 0, 16'h0BEE, 4'b0001);
        drain();

        set_b(1'b0, 1'b1, 11, 0, EXP11);
        issue_a(2, 1'b1, 11, 16'h0C0C, 0, 4'b0100);
        clear_b();
        b_op(1'b0, 1'b1, 11, 0, 16'h0C0C);
        drain();

        issue_a(0, 1'b1, 8100, 16'hFFFF, 0, 4'b0001);
        issue_a(0, 1'b0, 8100, 0, 16'h0000, 4'b0001);
        b_op(1'b0, 1'b1, 8100, 0, 16'h0000);
        drain();

        b_op(1'b1, 1'b1, 30, 16'h3030, 0);
        b_op(1'b0, 1'b1, 30, 0, 16'h3030);
        drain();

        issue_a(1, 1'b0, 5, 0, 16'h1234, 4'b0010);
        rst = 1'b1;
        qa.delete();
        issue_a(0, 1'b1, 20, 16'hDEAD, 0, 4'b0001);
        rst = 1'b0;

        for (int k = 0; k < NS; k++) begin
            cnt[k] = 0;
            addr[k*AW +: AW] = AW'(5);
        end
        req  = '1;
        wren = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(1 << (i % NS)));
            for (int k = 0; k < NS; k++) if (gnt[k]) cnt[k]++;
            qa.push_back('{i % NS, 16'h1234, cyc + 2});
            tick();
        end
        req = '0;
        for (int k = 0; k < NS; k++)
            chk($sformatf("rr_count_src%0d", k), 32'(cnt[k]), 2);
        drain();

        issue_a(3, 1'b0, 20, 0, 16'h0020, 4'b1000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weights_mem_arb.md
Name: weights_mem_arb

Overview:
- Parametrised successor to the two-source weights memory select.
- Arbitrates NUM_SRC requesters (convolution, FC and readback engines) onto port A of an inferred true-dual-port weights RAM.
- Port B stays a dedicated, always-serviced loader port.
- Round-robin grant, fixed pipelined read latency, and source tagging on returned data let several consumers share one weights store without external muxing.

Parameters:
- DATA_W, 16, weight word width in bits
- DEPTH, 8192, number of words
- ADDR_W, 13, address width; must satisfy 2**ADDR_W >= DEPTH
- NUM_SRC, 4, number of port-A requesters (2..8)
- SRC_W, 2, width of source tag; must satisfy 2**SRC_W >= NUM_SRC

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req  in  NUM_SRC  per-source access request
- addr  in  NUM_SRC*ADDR_W  per-source address, source i at bits [i*ADDR_W +: ADDR_W]
- wren  in  NUM_SRC  per-source write enable, qualified by grant
- wdata  in  NUM_SRC*DATA_W  per-source write data, same packing as addr
- gnt  out  NUM_SRC  one-hot grant, combinational, same cycle as req
- rd_valid  out  1  port-A read data valid
- rd_src  out  SRC_W  source index that issued the returned read
- rd_data  out  DATA_W  port-A read data
- addr_b  in  ADDR_W  loader address
- wren_b  in  1  loader write enable
- data_b  in  DATA_W  loader write data
- rd_b  in  1  loader read request
- q_b_valid  out  1  port-B read data valid
- q_b  out  DATA_W  port-B read data

Behaviour:
- Reset values:
  - Round-robin pointer = 0.
  - rd_valid, q_b_valid = 0; rd_src, rd_data, q_b = 0.
  - All pipeline valid bits cleared.
  - RAM contents are not reset.
- Arbitration:
  - gnt goes to the first asserted req at or after the pointer, searching cyclically.
  - gnt is all-zero when no req is asserted.
  - After a grant to source k, the pointer becomes (k+1) mod NUM_SRC.
  - The pointer holds when nothing is granted.
  - A requester holds req/addr/wren/wdata stable until it sees gnt; the access is accepted in the gnt cycle.
- Port-A access in the grant cycle:
  - Write (wren[k]=1): RAM updated at that edge; no rd_valid is produced.
  - Read: RAM read is registered at edge 1, output is registered at edge 2.
  - rd_valid/rd_src/rd_data are asserted exactly 2 cycles after the gnt cycle, for one cycle.
  - Back-to-back grants give one result per cycle, in grant order.
- Port B:
  - Writes are accepted every cycle with no arbitration.
  - Reads (rd_b=1, wren_b=0) return on q_b/q_b_valid after the same 2-cycle latency.
  - If rd_b and wren_b are both high, the cycle is a write and no read is issued.
- Same-address write on both ports in one cycle: port B data is stored.
- Out-of-range address (>= DEPTH): writes are ignored; reads return 0 with valid asserted as normal.
- Read-during-write on the same port and address returns the old data.
- Reset asserted mid-operation: in-flight reads are discarded, no valid is emitted for them, and the pointer returns to 0 on the reset edge. Grants issued in a reset cycle are not honoured.
- rd_valid and q_b_valid are deasserted in every cycle without a matured read.

Optional Feature:
- Macro: WEIGHTS_MEM_ARB_FWD_EN.
- Defined: cross-port forwarding. A port-A read and a port-B write to the same address in the same cycle return the new port-B data on rd_data. Symmetrically, a port-B read during a port-A write to the same address returns the new port-A data.
- Undefined: cross-port collisions return the old RAM contents.
- Latency is unchanged in both cases.

Decomposition:
- Package weights_mem_pkg:
  - Default constants DATA_W, DEPTH, ADDR_W.
  - Typedef weight_t (logic [DATA_W-1:0]).
  - Typedef waddr_t.
  - Function clog2-safe src_width(NUM_SRC).
- Sub-module rr_arbiter (parameter N): req, pointer update, one-hot gnt, grant index output.
- RAM array and pipeline stay in the top module.

Test Plan:
- Reset then single read: loader writes 0x1234 at addr 5 via port B; source 2 reads addr 5 -> gnt=4'b0100 same cycle; rd_valid two cycles later with rd_src=2, rd_data=0x1234.
- Round-robin fairness: req=4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, repeating; each source is granted exactly twice.
- Pipelined throughput: source 0 reads addrs 0..3 on consecutive grants, contents 0xA0..0xA3 -> rd_data 0xA0..0xA3 on four consecutive cycles with rd_valid held high.
- Write collision: source 1 writes 0x1111 and port B writes 0x2222 to addr 9 in the same cycle -> subsequent read of addr 9 returns 0x2222.
- Cross-port read collision: port-A read addr 7 (old 0x0007) while port B writes 0x0BEE to addr 7 -> rd_data=0x0BEE with WEIGHTS_MEM_ARB_FWD_EN defined, 0x0007 without.
- Reset mid-flight: grant a read, assert rst the next cycle -> no rd_valid ever appears for it; after release with req=4'b1111, first gnt=4'b0001.
